// File: rtl/usb_pipe_pkg.sv
// Shared PIPE receive definitions: K-code constants, RX_STATUS encodings and the
// ordered-set framer state type.
package usb_pipe_pkg;

  localparam logic [7:0] COM_K = 8'hBC;  // K28.5
  localparam logic [7:0] SKP_K = 8'h3C;  // K28.1
  localparam logic [7:0] SDP_K = 8'h5C;  // K28.2

  localparam logic [2:0] RxStOk     = 3'b000;
  localparam logic [2:0] RxStDecErr = 3'b100;
  localparam logic [2:0] RxStEbOvf  = 3'b101;
  localparam logic [2:0] RxStEbUnf  = 3'b110;
  localparam logic [2:0] RxStDispErr = 3'b111;

  typedef enum logic {StHunt, StCollect} os_state_e;

  function automatic logic is_rx_err(input logic [2:0] status);
    return status inside {RxStDecErr, RxStEbOvf, RxStEbUnf, RxStDispErr};
  endfunction

endpackage

// File: rtl/usb_rx_os_monitor_if.sv
// PIPE receive symbol stream in, framed ordered-set / data / error results out.
interface usb_rx_os_monitor_if;
  logic [7:0] RX_DATA;
  logic       RX_DATAK;
  logic       RX_VALID;
  logic [2:0] RX_STATUS;
  logic       OS_VALID;
  logic [7:0] OS_ID;
  logic       OS_LOCK;
  logic [7:0] DATA_OUT;
  logic       DATA_VLD;
  logic [7:0] ERR_CNT;
  logic       ERR_PULSE;

  modport master (
    output RX_DATA, RX_DATAK, RX_VALID, RX_STATUS,
    input  OS_VALID, OS_ID, OS_LOCK, DATA_OUT, DATA_VLD, ERR_CNT, ERR_PULSE
  );

  modport slave (
    input  RX_DATA, RX_DATAK, RX_VALID, RX_STATUS,
    output OS_VALID, OS_ID, OS_LOCK, DATA_OUT, DATA_VLD, ERR_CNT, ERR_PULSE
  );
endinterface

// File: rtl/usb_os_store.sv
// Reference/shadow pair of ordered-set symbol registers ({K, data} per entry).
// The shadow fills as a set arrives; copy_i moves it (including this cycle's write) to the store.
module usb_os_store #(
  parameter int unsigned OS_LEN = 16,
  localparam int unsigned IdxW  = $clog2(OS_LEN)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] idx_i,
  input  logic [8:0]      sym_i,
  input  logic            copy_i,
  output logic            hit_o,
  output logic [7:0]      shadow1_o
);

  logic [8:0] store_q  [OS_LEN];
  logic [8:0] store_d  [OS_LEN];
  logic [8:0] shadow_q [OS_LEN];
  logic [8:0] shadow_d [OS_LEN];

  always_comb begin
    shadow_d = shadow_q;
    store_d  = store_q;
    if (wr_en_i) shadow_d[idx_i] = sym_i;
    if (copy_i)  store_d = shadow_d;
  end

  assign hit_o     = (store_q[idx_i] == sym_i);
  assign shadow1_o = shadow_q[1][7:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      store_q  <= '{default: '0};
      shadow_q <= '{default: '0};
    end else begin
      store_q  <= store_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: rtl/usb_rx_os_monitor.sv
// PIPE receive monitor: frames COM-led ordered sets, tracks repeats for lock,
// forwards data symbols outside sets and counts PHY/framing errors.
module usb_rx_os_monitor
  import usb_pipe_pkg::*;
#(
  parameter int unsigned OS_LEN   = 16,
  parameter int unsigned LOCK_CNT = 8,
  parameter logic [7:0]  COM_SYM  = COM_K
) (
  input logic                PHY_CLK,
  input logic                PHY_RST,
  usb_rx_os_monitor_if.slave bus
);

  localparam int unsigned IdxW = $clog2(OS_LEN);

  os_state_e       state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            match_q, match_d;
  logic            store_vld_q, store_vld_d;
  logic [7:0]      rep_q, rep_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            os_valid_q, os_valid_d;
  logic [7:0]      os_id_q, os_id_d;
  logic            os_lock_q, os_lock_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            data_vld_q, data_vld_d;
  logic            err_pulse_q, err_pulse_d;

  logic       wr_en, copy, hit, is_com, st_err;
  logic [7:0] shadow1;

  usb_os_store #(
    .OS_LEN (OS_LEN)
  ) u_store (
    .clk_i     (PHY_CLK),
    .rst_ni    (PHY_RST),
    .wr_en_i   (wr_en),
    .idx_i     (idx_q),
    .sym_i     ({bus.RX_DATAK, bus.RX_DATA}),
    .copy_i    (copy),
    .hit_o     (hit),
    .shadow1_o (shadow1)
  );

  assign is_com = bus.RX_DATAK && (bus.RX_DATA == COM_SYM);
  assign st_err = is_rx_err(bus.RX_STATUS);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    match_d     = match_q;
    store_vld_d = store_vld_q;
    rep_d       = rep_q;
    err_cnt_d   = err_cnt_q;
    os_id_d     = os_id_q;
    os_lock_d   = os_lock_q;
    data_out_d  = data_out_q;
    os_valid_d  = 1'b0;
    data_vld_d  = 1'b0;
    err_pulse_d = 1'b0;
    wr_en       = 1'b0;
    copy        = 1'b0;

    if (bus.RX_VALID) begin
      if (st_err || (state_q == StCollect && is_com)) begin
        err_pulse_d = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        rep_d     = '0;
        os_lock_d = 1'b0;
        // A bare in-set COM restarts framing; any STATUS error drops back to hunting.
        if (state_q == StCollect && is_com && !st_err) begin
          idx_d   = IdxW'(1);
          match_d = 1'b1;
        end else begin
          state_d = StHunt;
        end
      end else if (state_q == StHunt) begin
        if (is_com) begin
          state_d = StCollect;
          idx_d   = IdxW'(1);
          match_d = 1'b1;
        end else if (!bus.RX_DATAK) begin
          data_vld_d = 1'b1;
          data_out_d = bus.RX_DATA;
        end
      end else begin
        wr_en   = 1'b1;
        // An empty store after reset must never count as a repeat.
        match_d = match_q && hit && store_vld_q;
        if (idx_q == IdxW'(OS_LEN - 1)) begin
          state_d    = StHunt;
          os_valid_d = 1'b1;
          os_id_d    = (OS_LEN == 2) ? bus.RX_DATA : shadow1;
          if (match_d) begin
            if (rep_q != 8'hFF) rep_d = rep_q + 8'd1;
          end else begin
            rep_d       = 8'd1;
            copy        = 1'b1;
            store_vld_d = 1'b1;
          end
          os_lock_d = (32'(rep_d) >= LOCK_CNT);
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
    end
  end

  always_ff @(posedge PHY_CLK or negedge PHY_RST) begin
    if (!PHY_RST) begin
      state_q     <= StHunt;
      idx_q       <= '0;
      match_q     <= 1'b0;
      store_vld_q <= 1'b0;
      rep_q       <= '0;
      err_cnt_q   <= '0;
      os_valid_q  <= 1'b0;
      os_id_q     <= '0;
      os_lock_q   <= 1'b0;
      data_out_q  <= '0;
      data_vld_q  <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      match_q     <= match_d;
      store_vld_q <= store_vld_d;
      rep_q       <= rep_d;
      err_cnt_q   <= err_cnt_d;
      os_valid_q  <= os_valid_d;
      os_id_q     <= os_id_d;
      os_lock_q   <= os_lock_d;
      data_out_q  <= data_out_d;
      data_vld_q  <= data_vld_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign bus.OS_VALID  = os_valid_q;
  assign bus.OS_ID     = os_id_q;
  assign bus.OS_LOCK   = os_lock_q;
  assign bus.DATA_OUT  = data_out_q;
  assign bus.DATA_VLD  = data_vld_q;
  assign bus.ERR_CNT   = err_cnt_q;
  assign bus.ERR_PULSE = err_pulse_q;

endmodule

// File: tb/tb_usb_rx_os_monitor.sv
// Bench for usb_rx_os_monitor: directed scenarios plus a random symbol stream, all
// checked against a set-level model (queues of whole ordered sets, not symbol counters).
module tb_usb_rx_os_monitor;

  localparam int OS_LEN   = 16;
  localparam int LOCK_CNT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  usb_rx_os_monitor_if bus ();

  usb_rx_os_monitor #(
    .OS_LEN   (OS_LEN),
    .LOCK_CNT (LOCK_CNT),
    .COM_SYM  (8'hBC)
  ) dut (
    .PHY_CLK (clk),
    .PHY_RST (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] base_set [16] = '{8'hBC, 8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02,
                                8'h82, 8'h72, 8'h6E, 8'h28, 8'hA6, 8'hBE, 8'h6D, 8'hBF};

  // Reference model state: the set being received and the last accepted set.
  bit         m_in_set;
  bit [8:0]   m_cur [$];
  bit [8:0]   m_prev [OS_LEN-1];
  bit         m_prev_vld;
  int         m_rep;
  int         m_err;
  logic       e_osv, e_lock, e_dv, e_ep;
  logic [7:0] e_id, e_do;

  task automatic model_reset();
    m_in_set = 0; m_cur.delete(); m_prev_vld = 0; m_rep = 0; m_err = 0;
    e_osv = 0; e_lock = 0; e_dv = 0; e_ep = 0; e_id = '0; e_do = '0;
  endtask

  task automatic model(input bit v, input bit k, input logic [7:0] d, input logic [2:0] st);
    bit err, com, same;
    e_osv = 0; e_dv = 0; e_ep = 0;
    if (!v) return;
    err = (st >= 3'd4);
    com = k && (d == 8'hBC);
    if (err || (m_in_set && com)) begin
      e_ep = 1;
      if (m_err < 255) m_err++;
      m_rep = 0; e_lock = 0;
      if (m_in_set && com && !err) m_cur.delete();
      else m_in_set = 0;
    end else if (!m_in_set) begin
      if (com) begin
        m_in_set = 1; m_cur.delete();
      end else if (!k) begin
        e_dv = 1; e_do = d;
      end
    end else begin
      m_cur.push_back({k, d});
      if (m_cur.size() == OS_LEN - 1) begin
        same = m_prev_vld;
        for (int i = 0; i < OS_LEN - 1; i++) if (m_cur[i] != m_prev[i]) same = 0;
        if (same) begin
          if (m_rep < 255) m_rep++;
        end else begin
          m_rep = 1;
          for (int i = 0; i < OS_LEN - 1; i++) m_prev[i] = m_cur[i];
          m_prev_vld = 1;
        end
        e_osv = 1; e_id = m_cur[0][7:0]; e_lock = (m_rep >= LOCK_CNT);
        m_in_set = 0;
      end
    end
  endtask

  task automatic step(input bit v, input bit k, input logic [7:0] d, input logic [2:0] st);
    bus.RX_VALID = v; bus.RX_DATAK = k; bus.RX_DATA = d; bus.RX_STATUS = st;
    model(v, k, d, st);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] set_sym(input int i, input logic [7:0] last);
    if (i == 0) return {1'b1, 8'hBC};
    if (i == OS_LEN - 1) return {1'b0, last};
    return {1'b0, base_set[i]};
  endfunction

  task automatic test_reset();
    rst_n = 0;
    bus.RX_VALID = 0; bus.RX_DATAK = 0; bus.RX_DATA = '0; bus.RX_STATUS = '0;
    model_reset();
    #1;
    checks++;
    if ({bus.OS_VALID, bus.OS_ID, bus.OS_LOCK, bus.DATA_OUT, bus.DATA_VLD, bus.ERR_CNT,
         bus.ERR_PULSE} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got id=%h do=%h ec=%h flags=%b%b%b%b, want all 0",
               bus.OS_ID, bus.DATA_OUT, bus.ERR_CNT, bus.OS_VALID, bus.OS_LOCK, bus.DATA_VLD,
               bus.ERR_PULSE);
    end
    #11 rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_set();
    logic [8:0] s;
    int pulses = 0;
    for (int i = 0; i < OS_LEN; i++) begin
      s = set_sym(i, 8'hBF);
      step(1, s[8], s[7:0], 3'b000);
      if (bus.OS_VALID) pulses++;
      checks++;
      if (bus.OS_VALID !== e_osv) begin
        errors++; $display("FAIL single_os_valid[%0d]: got %b want %b", i, bus.OS_VALID, e_osv);
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", pulses); end
    checks++;
    if (bus.OS_ID !== 8'hFF) begin errors++; $display("FAIL single_id: got %h want FF", bus.OS_ID); end
    checks++;
    if (bus.OS_LOCK !== 1'b0) begin errors++; $display("FAIL single_lock: got %b want 0", bus.OS_LOCK); end
    checks++;
    if (bus.ERR_CNT !== 8'h00) begin errors++; $display("FAIL single_errcnt: got %h want 00", bus.ERR_CNT); end
  endtask

  task automatic test_lock();
    logic [8:0] s;
    int pulses = 0;
    for (int n = 0; n < 9; n++) begin
      for (int i = 0; i < OS_LEN; i++) begin
        s = set_sym(i, (n == 8) ? 8'h4A : 8'hBF);
        step(1, s[8], s[7:0], 3'b000);
        if (bus.OS_VALID) pulses++;
        checks++;
        if (bus.OS_VALID !== e_osv || bus.OS_LOCK !== e_lock) begin
          errors++;
          $display("FAIL lock_seq[%0d.%0d]: got valid=%b lock=%b want valid=%b lock=%b",
                   n, i, bus.OS_VALID, bus.OS_LOCK, e_osv, e_lock);
        end
      end
      if (n == 7) begin
        checks++;
        if (bus.OS_LOCK !== 1'b1) begin errors++; $display("FAIL lock_rise: got %b want 1", bus.OS_LOCK); end
      end
    end
    checks++;
    if (bus.OS_LOCK !== 1'b0) begin errors++; $display("FAIL lock_drop: got %b want 0", bus.OS_LOCK); end
    checks++;
    if (pulses != 9) begin errors++; $display("FAIL lock_pulses: got %0d want 9", pulses); end
  endtask

  task automatic test_data();
    int sent = 0, vld = 0, cyc = 0;
    bit v;
    while (sent < 20 && cyc < 200) begin
      v = ($urandom_range(0, 3) != 0);
      step(v, 0, 8'h4A, 3'b000);
      if (v) sent++;
      cyc++;
      if (bus.DATA_VLD) vld++;
      checks++;
      if (bus.DATA_VLD !== e_dv || bus.DATA_OUT !== e_do || bus.OS_VALID !== 1'b0) begin
        errors++;
        $display("FAIL data_fwd[%0d]: got vld=%b do=%h osv=%b want vld=%b do=%h osv=0",
                 cyc, bus.DATA_VLD, bus.DATA_OUT, bus.OS_VALID, e_dv, e_do);
      end
    end
    checks++;
    if (vld != 20) begin errors++; $display("FAIL data_count: got %0d want 20", vld); end
  endtask

  task automatic test_status_err();
    logic [8:0] s;
    int pulses = 0;
    for (int i = 0; i <= 5; i++) begin
      s = set_sym(i, 8'hBF);
      step(1, s[8], s[7:0], (i == 5) ? 3'b111 : 3'b000);
      if (bus.OS_VALID) pulses++;
    end
    checks++;
    if (bus.ERR_PULSE !== 1'b1 || bus.ERR_CNT !== 8'h01 || bus.OS_LOCK !== 1'b0 || pulses != 0) begin
      errors++;
      $display("FAIL status_err: got pulse=%b cnt=%h lock=%b osv=%0d want 1/01/0/0",
               bus.ERR_PULSE, bus.ERR_CNT, bus.OS_LOCK, pulses);
    end
    for (int i = 0; i < OS_LEN; i++) begin
      s = set_sym(i, 8'hBF);
      step(1, s[8], s[7:0], 3'b000);
      if (bus.OS_VALID) pulses++;
    end
    checks++;
    if (pulses != 1 || bus.OS_LOCK !== e_lock || m_rep != 1) begin
      errors++;
      $display("FAIL status_recover: got osv=%0d lock=%b want osv=1 lock=%b rep=1",
               pulses, bus.OS_LOCK, e_lock);
    end
  endtask

  task automatic test_com_restart();
    logic [8:0] s;
    int pulses = 0;
    for (int i = 0; i < 7; i++) begin
      s = set_sym(i, 8'hBF);
      step(1, s[8], s[7:0], 3'b000);
    end
    step(1, 1, 8'hBC, 3'b000);
    checks++;
    if (bus.ERR_PULSE !== 1'b1 || bus.ERR_CNT !== 8'h02) begin
      errors++;
      $display("FAIL com_err: got pulse=%b cnt=%h want 1/02", bus.ERR_PULSE, bus.ERR_CNT);
    end
    for (int i = 1; i < OS_LEN; i++) begin
      s = set_sym(i, 8'hBF);
      step(1, s[8], s[7:0], 3'b000);
      if (bus.OS_VALID) pulses++;
    end
    checks++;
    if (pulses != 1 || bus.OS_VALID !== 1'b1 || bus.OS_ID !== 8'hFF) begin
      errors++;
      $display("FAIL com_restart: got osv=%0d last=%b id=%h want 1/1/FF", pulses, bus.OS_VALID,
               bus.OS_ID);
    end
  endtask

  task automatic test_random();
    int ptr = 0, r;
    bit v, k;
    logic [7:0] d;
    logic [2:0] st;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 99);
      v = ($urandom_range(0, 99) < 85);
      st = ($urandom_range(0, 99) < 3) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
      if (r < 70) begin
        k = (ptr == 0); d = base_set[ptr];
        if (ptr == OS_LEN - 1 && $urandom_range(0, 9) == 0) d = 8'($urandom);
        if (v) ptr = (ptr + 1) % OS_LEN;
      end else if (r < 80) begin
        k = 0; d = 8'($urandom);
      end else if (r < 85) begin
        k = 1; d = 8'hBC;
      end else begin
        k = 1; d = 8'($urandom);
      end
      step(v, k, d, st);
      checks++;
      if (bus.OS_VALID !== e_osv || bus.OS_ID !== e_id || bus.OS_LOCK !== e_lock ||
          bus.DATA_VLD !== e_dv || bus.DATA_OUT !== e_do || bus.ERR_PULSE !== e_ep ||
          bus.ERR_CNT !== 8'(m_err)) begin
        errors++;
        $display("FAIL random[%0d]: got osv=%b id=%h lk=%b dv=%b do=%h ep=%b ec=%h want %b %h %b %b %h %b %h",
                 c, bus.OS_VALID, bus.OS_ID, bus.OS_LOCK, bus.DATA_VLD, bus.DATA_OUT,
                 bus.ERR_PULSE, bus.ERR_CNT, e_osv, e_id, e_lock, e_dv, e_do, e_ep, 8'(m_err));
      end
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      step(1, 0, 8'($urandom), 3'b100);
      checks++;
      if (bus.ERR_PULSE !== 1'b1 || bus.ERR_CNT !== 8'(m_err) || bus.DATA_VLD !== 1'b0) begin
        errors++;
        $display("FAIL saturate[%0d]: got pulse=%b cnt=%h dv=%b want 1/%h/0", i, bus.ERR_PULSE,
                 bus.ERR_CNT, bus.DATA_VLD, 8'(m_err));
      end
    end
    checks++;
    if (bus.ERR_CNT !== 8'hFF) begin errors++; $display("FAIL saturate_final: got %h want FF", bus.ERR_CNT); end
  endtask

  task automatic test_reset_mid();
    logic [8:0] s;
    int pulses = 0;
    for (int i = 0; i < 6; i++) begin
      s = set_sym(i, 8'hBF);
      step(1, s[8], s[7:0], 3'b000);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({bus.OS_VALID, bus.OS_ID, bus.OS_LOCK, bus.DATA_OUT, bus.DATA_VLD, bus.ERR_CNT,
         bus.ERR_PULSE} !== 27'd0) begin
      errors++;
      $display("FAIL reset_mid: got id=%h do=%h ec=%h lk=%b want all 0", bus.OS_ID, bus.DATA_OUT,
               bus.ERR_CNT, bus.OS_LOCK);
    end
    bus.RX_VALID = 0;
    model_reset();
    #3 rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < OS_LEN; i++) begin
      s = set_sym(i, 8'hBF);
      step(1, s[8], s[7:0], 3'b000);
      if (bus.OS_VALID) pulses++;
    end
    checks++;
    if (pulses != 1 || bus.OS_LOCK !== e_lock || bus.ERR_CNT !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_resume: got osv=%0d lock=%b cnt=%h want 1/%b/00", pulses,
               bus.OS_LOCK, bus.ERR_CNT, e_lock);
    end
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_lock();
    test_data();
    test_status_err();
    test_com_restart();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
